// File: rtl/uart_trans_core_pkg.sv
// Shared types and constants for the UART transmit core.
// Holds the frame state encoding, the default oversampling ratio and the idle line level.
package uart_trans_core_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int unsigned OVERSAMPLE_DEFAULT = 16;
    localparam logic        IDLE_LEVEL         = 1'b1;

endpackage

// File: rtl/uart_trans_core.sv
// UART transmitter sending an auto-incrementing byte as 8N1 frames on a 16x sampling clock.
// ack advances to the next byte, resend repeats the current one; USB_RTS gates frame start.
module uart_trans_core
    import uart_trans_core_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic uart_sampling_clk,
    input  logic rst,
    input  logic ack,
    input  logic resend,
    input  logic USB_RTS,
    output logic USB_TX
);

    localparam logic [3:0] LastSample = 4'(OVERSAMPLE - 1);

    uart_state_e cs, ns;
    logic [7:0]  uart_byte, uart_byte_d;
    logic [2:0]  bit_count, bit_count_d;
    logic [3:0]  sample_cnt_q, sample_cnt_d;
    logic        tx_q, tx_d;
    logic        sample_last;

    assign sample_last = (sample_cnt_q == LastSample);

    always_comb begin
        ns           = cs;
        uart_byte_d  = uart_byte;
        bit_count_d  = bit_count;
        tx_d         = IDLE_LEVEL;
        sample_cnt_d = (cs == IDLE || sample_last) ? 4'd0 : sample_cnt_q + 4'd1;
        case (cs)
            IDLE: begin
                // ack takes priority over resend when both are high.
                if (!USB_RTS && (ack || resend)) begin
                    ns = START;
                    if (ack) begin
                        uart_byte_d = uart_byte + 8'd1;
                    end
                end
            end
            START: begin
                tx_d = 1'b0;
                if (sample_last) begin
                    ns          = DATA;
                    bit_count_d = 3'd0;
                end
            end
            DATA: begin
                tx_d = uart_byte[bit_count];
                if (sample_last) begin
                    if (bit_count == 3'd7) begin
                        ns = STOP;
                    end else begin
                        bit_count_d = bit_count + 3'd1;
                    end
                end
            end
            STOP: begin
                tx_d = IDLE_LEVEL;
                if (sample_last) begin
                    ns = IDLE;
                end
            end
            default: ns = IDLE;
        endcase
    end

    // The line level is registered from the current state, so it trails the state by one clock.
    always_ff @(posedge uart_sampling_clk or negedge rst) begin
        if (!rst) begin
            cs           <= IDLE;
            uart_byte    <= 8'h00;
            bit_count    <= 3'd0;
            sample_cnt_q <= 4'd0;
            tx_q         <= IDLE_LEVEL;
        end else begin
            cs           <= ns;
            uart_byte    <= uart_byte_d;
            bit_count    <= bit_count_d;
            sample_cnt_q <= sample_cnt_d;
            tx_q         <= tx_d;
        end
    end

    assign USB_TX = tx_q;

endmodule

// File: tb/tb_uart_trans_core.sv
// Self-checking bench for uart_trans_core: vector table, corner-case sequences and random traffic
// compared every clock against a waveform-queue reference model.
module tb_uart_trans_core;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ack = 1'b0;
    logic resend = 1'b0;
    logic rts = 1'b1;
    logic tx;

    always #5 clk = ~clk;

    uart_trans_core #(
        .OVERSAMPLE(16)
    ) dut (
        .uart_sampling_clk(clk),
        .rst              (rst),
        .ack              (ack),
        .resend           (resend),
        .USB_RTS          (rts),
        .USB_TX           (tx)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the byte counter and the queue of line levels still owed by the frame.
    logic [7:0] mdl_byte = 8'h00;
    logic       exp_q[$];
    logic       exp_tx = 1'b1;

    typedef struct {
        logic       a;
        logic       r;
        logic       rr;
        logic       frame;
        logic [7:0] byte_v;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic a, input logic r, input logic rr);
        logic lvl;
        if (exp_q.size() > 0) begin
            exp_tx = exp_q.pop_front();
        end else begin
            exp_tx = 1'b1;
            if (!rr && (a || r)) begin
                if (a) mdl_byte = mdl_byte + 8'd1;
                for (int s = 0; s < 10; s++) begin
                    if (s == 0)      lvl = 1'b0;
                    else if (s == 9) lvl = 1'b1;
                    else             lvl = mdl_byte[s-1];
                    repeat (16) exp_q.push_back(lvl);
                end
            end
        end
    endtask

    task automatic tick(input logic a, input logic r, input logic rr);
        ack    = a;
        resend = r;
        rts    = rr;
        @(posedge clk);
        model_step(a, r, rr);
        #1;
        check("usb_tx", {31'd0, tx}, {31'd0, exp_tx});
    endtask

    // Runs 170 quiet clocks after a request edge and decodes whatever frame appears.
    task automatic capture(output logic [7:0] b, output int first_low);
        logic c[170];
        int   base;
        int   idx;
        for (int i = 0; i < 170; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            c[i] = tx;
        end
        first_low = -1;
        for (int i = 169; i >= 0; i--) begin
            if (c[i] === 1'b0) first_low = i;
        end
        base = (first_low >= 0) ? first_low : 0;
        b = 8'h00;
        for (int k = 0; k < 8; k++) begin
            idx = base + 16 + 16 * k + 8;
            if (idx < 170) b[k] = c[idx];
        end
    endtask

    task automatic request_and_check(input string name, input logic a, input logic r, input logic rr,
                                     input logic frame, input logic [7:0] exp_b);
        logic [7:0] got_b;
        int         first_low;
        tick(a, r, rr);
        capture(got_b, first_low);
        check({name, "_start"}, first_low, frame ? 0 : -1);
        if (frame) check({name, "_byte"}, {24'd0, got_b}, {24'd0, exp_b});
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{a: 1'b1, r: 1'b0, rr: 1'b0, frame: 1'b1, byte_v: 8'h01};
        vecs[1] = '{a: 1'b0, r: 1'b1, rr: 1'b0, frame: 1'b1, byte_v: 8'h01};
        vecs[2] = '{a: 1'b0, r: 1'b1, rr: 1'b1, frame: 1'b0, byte_v: 8'h00};
        vecs[3] = '{a: 1'b1, r: 1'b0, rr: 1'b1, frame: 1'b0, byte_v: 8'h00};
        vecs[4] = '{a: 1'b1, r: 1'b1, rr: 1'b0, frame: 1'b1, byte_v: 8'h02};
        vecs[5] = '{a: 1'b0, r: 1'b1, rr: 1'b0, frame: 1'b1, byte_v: 8'h02};

        #12;
        check("reset_tx", {31'd0, tx}, 32'd1);
        #10 rst = 1'b1;

        foreach (vecs[i]) begin
            request_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].r, vecs[i].rr,
                              vecs[i].frame, vecs[i].byte_v);
        end

        // ack held while the receiver is busy, then released by USB_RTS falling.
        repeat (50) tick(1'b1, 1'b0, 1'b1);
        request_and_check("rts_release", 1'b1, 1'b0, 1'b0, 1'b1, 8'h03);

        // Requests during a frame are dropped; a later resend still shows the original byte.
        tick(1'b1, 1'b0, 1'b0);
        repeat (40) tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        repeat (60) tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        drain();
        repeat (30) tick(1'b0, 1'b0, 1'b0);
        request_and_check("midframe_ignored", 1'b0, 1'b1, 1'b0, 1'b1, 8'h04);

        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) == 0);
        end
        drain();

        // Reset while in the data bits must release the line at once.
        tick(1'b1, 1'b0, 1'b0);
        repeat (40) tick(1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("reset_midframe_tx", {31'd0, tx}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held_tx", {31'd0, tx}, 32'd1);
        #3 rst = 1'b1;
        exp_q.delete();
        mdl_byte = 8'h00;
        request_and_check("after_reset", 1'b1, 1'b0, 1'b0, 1'b1, 8'h01);

        // Walk the byte up to 0xFF with back-to-back frames, then wrap to 0x00.
        for (int i = 0; i < 60000 && mdl_byte != 8'hFF; i++) tick(1'b1, 1'b0, 1'b0);
        drain();
        request_and_check("wrap", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_trans_core.md
UART_TRANS_CORE -- requirements
Module: uart_trans

Interface
REQ-001 The block SHALL have the port uart_sampling_clk, input, 1 bit: the sampling clock at 16x the baud rate; all logic is on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have the port ack, input, 1 bit: host acknowledge; a high level requests transmission of the next byte.
REQ-004 The block SHALL have the port resend, input, 1 bit: a high level requests retransmission of the current byte.
REQ-005 The block SHALL have the port USB_RTS, input, 1 bit: active-low flow control; 0 means the receiver is ready.
REQ-006 The block SHALL have the port USB_TX, output, 1 bit: the registered serial line; it is high when idle.
REQ-007 The block SHALL have the parameter OVERSAMPLE, default 16: sampling clocks per bit.

Function
REQ-008 The state machine SHALL have states IDLE, START, DATA and STOP, held in cs (current) and ns (next).
REQ-009 uart_byte SHALL be an 8-bit register holding the byte being sent.
REQ-010 bit_count SHALL be a 3-bit data-bit index; a 4-bit sample counter SHALL count 0..OVERSAMPLE-1.
REQ-011 In IDLE, when ack=1 and USB_RTS=0 at a clock edge: uart_byte <= uart_byte+1 (mod 256, 0xFF wraps to 0x00), and the next state is START.
REQ-012 In IDLE, when resend=1, ack=0 and USB_RTS=0: uart_byte is unchanged, and the next state is START.
REQ-013 If ack and resend are both high, ack SHALL win and resend SHALL be ignored.
REQ-014 In IDLE, when USB_RTS=1, requests SHALL NOT start a frame; a held ack or resend level is acted on once USB_RTS falls.
REQ-015 Requests while not in IDLE SHALL be ignored; they are neither queued nor counted.
REQ-016 In START, USB_TX SHALL be 0 for exactly OVERSAMPLE clocks, then the block SHALL go to DATA with bit_count=0.
REQ-017 In DATA, USB_TX SHALL be uart_byte[bit_count], sent LSB first, each bit for OVERSAMPLE clocks.
REQ-018 After bit 7, the block SHALL go to STOP.
REQ-019 In STOP, USB_TX SHALL be 1 for OVERSAMPLE clocks, then the block SHALL return to IDLE.
REQ-020 A frame SHALL last exactly 10*OVERSAMPLE = 160 clocks.
REQ-021 USB_TX SHALL fall at the first edge after the accepting edge.
REQ-022 USB_RTS changes mid-frame SHALL NOT abort or stall the frame.
REQ-023 uart_byte SHALL be stable throughout a frame.
REQ-024 The block SHALL accept a new request on the first IDLE edge after STOP.
REQ-025 USB_TX SHALL be driven directly from a flip-flop, with no combinational glitches.

Reset
REQ-026 While rst=0 (asynchronously): cs=IDLE, USB_TX=1, uart_byte=8'h00, bit_count=0, sample counter=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately; the line SHALL return high.
REQ-028 After rst rises, the first request SHALL be evaluated on the next rising edge.

Structure
REQ-029 A shared package SHALL hold the state enum type (IDLE, START, DATA, STOP), the OVERSAMPLE default and the IDLE_LEVEL=1'b1 constant.
REQ-030 The block SHALL be a single module with no sub-modules; the sample counter, bit counter and FSM are inline.

Verification
REQ-031 Reset then ack pulse with USB_RTS=0 -> frame carries 0x01: TX low 16 clocks, then bits 1,0,0,0,0,0,0,0 at 16 clocks each, then high 16 clocks; back in IDLE at clock 160.
REQ-032 Following resend pulse -> identical 0x01 frame; uart_byte remains 0x01.
REQ-033 Hold USB_RTS=1 with ack=1 for 50 clocks -> TX stays 1; USB_RTS drops -> frame 0x02 starts the next clock.
REQ-034 ack and resend high together -> byte increments (0x02 to 0x03); ack pulse mid-frame -> ignored, no extra frame.
REQ-035 Preload uart_byte=0xFF by 255 acks, then ack -> 0x00 frame (all data bits 0).
REQ-036 rst=0 during the DATA state -> TX=1 and cs=IDLE immediately, uart_byte=0x00.
